// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage F/D/X/M/W RISC-V core.
// Tracks the instructions in X, M and W in a shadow scoreboard and derives
// load-use / RAW stalls, redirect flushes, X operand forwarding selects and
// saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned AW             = 5,
  parameter bit          MODE_FWD       = 1'b1,
  parameter bit          RF_WRITE_FIRST = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_rs1,
  input  logic [AW-1:0]    d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [AW-1:0]    d_rd,
  input  logic             d_we,
  input  logic             d_load,
  input  logic             x_redirect,
  output logic             stall_fd,
  output logic             flush_d,
  output logic             bubble_x,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          we;
    logic          load;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
  } sb_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_e;

  typedef enum logic [1:0] {
    FWD_RS1X  = 2'd0,
    FWD_ALUM  = 2'd1,
    FWD_DATAW = 2'd2
  } fwd_e;

  sb_t              r_x, r_m, r_w;
  sb_t              w_d;
  logic             w_src1, w_src2;
  logic             w_hit1, w_hit2;
  logic             w_hazard;
  logic             w_stall;
  hz_e              w_hz;
  fwd_e             w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_unused;

  // Entry e writes architectural register r (x0 never counts as written).
  function automatic logic f_match(input sb_t e, input logic [AW-1:0] r);
    return e.valid & e.we & (e.rd != '0) & (e.rd == r);
  endfunction

  // Operand source for the X instruction: M beats W, otherwise register file.
  function automatic fwd_e f_fwd(input sb_t x, input sb_t m, input sb_t w,
                                 input logic [AW-1:0] rs, input logic use_rs);
    if (!x.valid || !use_rs) return FWD_RS1X;
    if (f_match(m, rs))      return FWD_ALUM;
    if (f_match(w, rs))      return FWD_DATAW;
    return FWD_RS1X;
  endfunction

  // Pack the D-stage decode into a scoreboard entry.
  always_comb begin
    w_d         = '0;
    w_d.valid   = d_valid;
    w_d.rd      = d_rd;
    w_d.we      = d_we;
    w_d.load    = d_load;
    w_d.rs1     = d_rs1;
    w_d.rs2     = d_rs2;
    w_d.use_rs1 = d_use_rs1;
    w_d.use_rs2 = d_use_rs2;
  end

  // Detect a RAW hazard between the D sources and in-flight writers.
  always_comb begin
    w_src1   = d_valid & d_use_rs1 & (d_rs1 != '0);
    w_src2   = d_valid & d_use_rs2 & (d_rs2 != '0);
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_hazard = 1'b0;
    if (MODE_FWD) begin
      w_hit1   = f_match(r_x, d_rs1);
      w_hit2   = f_match(r_x, d_rs2);
      w_hazard = r_x.load & ((w_src1 & w_hit1) | (w_src2 & w_hit2));
    end else begin
      w_hit1   = f_match(r_x, d_rs1) | f_match(r_m, d_rs1) |
                 (!RF_WRITE_FIRST & f_match(r_w, d_rs1));
      w_hit2   = f_match(r_x, d_rs2) | f_match(r_m, d_rs2) |
                 (!RF_WRITE_FIRST & f_match(r_w, d_rs2));
      w_hazard = (w_src1 & w_hit1) | (w_src2 & w_hit2);
    end
  end

  // A redirect kills the wrong-path D instruction, so it overrides the stall.
  always_comb begin
    w_stall = w_hazard & !x_redirect & !rest;
    if (rest)            w_hz = HZ_RUN;
    else if (x_redirect) w_hz = HZ_FLUSH;
    else if (w_stall)    w_hz = HZ_STALL;
    else                 w_hz = HZ_RUN;
  end

  // X operand forwarding selects; idle in no-forwarding mode and in reset.
  always_comb begin
    w_fwd_a = FWD_RS1X;
    w_fwd_b = FWD_RS1X;
    if (MODE_FWD && !rest) begin
      w_fwd_a = f_fwd(r_x, r_m, r_w, r_x.rs1, r_x.use_rs1);
      w_fwd_b = f_fwd(r_x, r_m, r_w, r_x.rs2, r_x.use_rs2);
    end
  end

  // Shadow scoreboard: X takes D or a bubble, M and W always advance.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_x <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_x <= bubble_x ? '0 : w_d;
      r_m <= r_x;
      r_w <= r_m;
    end
  end

  // Saturating stall and redirect event counters.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (x_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_fd  = w_stall;
  assign flush_d   = x_redirect;
  assign bubble_x  = w_stall | x_redirect;
  assign fwd_a_sel = w_fwd_a;
  assign fwd_b_sel = w_fwd_b;
  assign hz_state  = w_hz;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // W-stage source fields are carried for completeness but never consulted.
  assign w_unused = ^{r_w.load, r_w.rs1, r_w.rs2, r_w.use_rs1, r_w.use_rs2};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding instance driven from a
// per-cycle vector table, plus no-forwarding instances and saturation/reset.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rest;

  always #5 clk = ~clk;

  // Forwarding instance, 4-bit counters
  logic       a_v, a_u1, a_u2, a_we, a_ld, a_rdr;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic       a_stall, a_flush, a_bub;
  logic [1:0] a_fa, a_fb, a_hz;
  logic [3:0] a_sc, a_fc;

  // Shared stimulus for the two no-forwarding instances
  logic       n_v, n_u1, n_u2, n_we, n_ld, n_rdr;
  logic [4:0] n_rs1, n_rs2, n_rd;
  logic        b_stall, b_flush, b_bub, c_stall, c_flush, c_bub;
  logic [1:0]  b_fa, b_fb, b_hz, c_fa, c_fb, c_hz;
  logic [15:0] b_sc, b_fc, c_sc, c_fc;

  pipe_hazard_ctrl #(.AW(5), .MODE_FWD(1'b1), .RF_WRITE_FIRST(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rest(rest), .d_valid(a_v), .d_rs1(a_rs1), .d_rs2(a_rs2),
    .d_use_rs1(a_u1), .d_use_rs2(a_u2), .d_rd(a_rd), .d_we(a_we), .d_load(a_ld),
    .x_redirect(a_rdr), .stall_fd(a_stall), .flush_d(a_flush), .bubble_x(a_bub),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .hz_state(a_hz), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_hazard_ctrl #(.AW(5), .MODE_FWD(1'b0), .RF_WRITE_FIRST(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rest(rest), .d_valid(n_v), .d_rs1(n_rs1), .d_rs2(n_rs2),
    .d_use_rs1(n_u1), .d_use_rs2(n_u2), .d_rd(n_rd), .d_we(n_we), .d_load(n_ld),
    .x_redirect(n_rdr), .stall_fd(b_stall), .flush_d(b_flush), .bubble_x(b_bub),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .hz_state(b_hz), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  pipe_hazard_ctrl #(.AW(5), .MODE_FWD(1'b0), .RF_WRITE_FIRST(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rest(rest), .d_valid(n_v), .d_rs1(n_rs1), .d_rs2(n_rs2),
    .d_use_rs1(n_u1), .d_use_rs2(n_u2), .d_rd(n_rd), .d_we(n_we), .d_load(n_ld),
    .x_redirect(n_rdr), .stall_fd(c_stall), .flush_d(c_flush), .bubble_x(c_bub),
    .fwd_a_sel(c_fa), .fwd_b_sel(c_fb), .hz_state(c_hz), .stall_cnt(c_sc), .flush_cnt(c_fc)
  );

  typedef struct {
    int v, rs1, rs2, u1, u2, rd, we, ld, rdr;
    int st, fl, bu, fa, fb, hz, sc, fc;
  } vec_t;

  vec_t tbl[32];
  int   checks = 0;
  int   errors = 0;
  bit   x_ld = 1'b0;
  bit   m_ld = 1'b0;
  int   eb[4] = '{1, 1, 0, 0};
  int   ec[4] = '{1, 1, 1, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one D-stage instruction for one cycle; sample 1 ns after negedge.
  task automatic drive_a(input vec_t t);
    @(negedge clk);
    a_v   = t.v[0];   a_rs1 = t.rs1[4:0]; a_rs2 = t.rs2[4:0];
    a_u1  = t.u1[0];  a_u2  = t.u2[0];    a_rd  = t.rd[4:0];
    a_we  = t.we[0];  a_ld  = t.ld[0];    a_rdr = t.rdr[0];
    #1;
    if (m_ld) begin
      checks++;
      if (a_fa == 2'd1 || a_fb == 2'd1) begin
        errors++;
        $display("FAIL m_load_fwd: fwd_a_sel %0d fwd_b_sel %0d with a load in M", a_fa, a_fb);
      end
    end
    m_ld = x_ld;
    x_ld = t.v[0] & t.we[0] & t.ld[0] & (t.rd != 0) & !a_bub;
  endtask

  task automatic apply_a(input int idx);
    vec_t t;
    t = tbl[idx];
    drive_a(t);
    chk($sformatf("r%0d stall_fd", idx), a_stall, t.st);
    chk($sformatf("r%0d flush_d", idx), a_flush, t.fl);
    chk($sformatf("r%0d bubble_x", idx), a_bub, t.bu);
    chk($sformatf("r%0d fwd_a", idx), a_fa, t.fa);
    chk($sformatf("r%0d fwd_b", idx), a_fb, t.fb);
    chk($sformatf("r%0d hz_state", idx), a_hz, t.hz);
    chk($sformatf("r%0d stall_cnt", idx), a_sc, t.sc);
    chk($sformatf("r%0d flush_cnt", idx), a_fc, t.fc);
  endtask

  task automatic drive_n(input int v, input int rs1, input int rs2, input int rd);
    @(negedge clk);
    n_v = v[0]; n_rs1 = rs1[4:0]; n_rs2 = rs2[4:0]; n_rd = rd[4:0];
    n_u1 = v[0]; n_u2 = v[0]; n_we = v[0]; n_ld = 1'b0; n_rdr = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lw5, cons;
    //           v rs1 rs2 u1 u2 rd we ld rdr | st fl bu fa fb hz sc fc
    tbl[0]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // add x5,x1,x2
    tbl[1]  = '{1, 5, 3, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // add x6,x5,x3
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0}; // x6 in X: A from M
    tbl[3]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // add x7
    tbl[4]  = '{1, 1, 1, 1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // filler add x9
    tbl[5]  = '{1, 7, 3, 1, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // add x8,x7,x3
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 0, 0, 0}; // A from W
    tbl[7]  = '{1, 1, 0, 1, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0}; // lw x5,0(x1)
    tbl[8]  = '{1, 2, 5, 1, 1, 6, 1, 0, 0,   1, 0, 1, 0, 0, 1, 0, 0}; // add x6,x2,x5 stalls
    tbl[9]  = '{1, 2, 5, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0}; // held, released
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 0, 1, 0}; // B from W
    tbl[11] = '{1, 1, 0, 1, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0}; // lw x0
    tbl[12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0}; // add x0,x0,x0
    tbl[13] = '{1, 0, 0, 1, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0}; // add x1,x0,x0
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0};
    tbl[15] = '{1, 3, 0, 1, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1, 0}; // lw x5,0(x3)
    tbl[16] = '{1, 5, 5, 1, 1, 6, 1, 0, 1,   0, 1, 1, 0, 0, 2, 1, 0}; // load-use + redirect
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1};
    tbl[18] = '{1, 1, 2, 1, 1,10, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1}; // add x10
    tbl[19] = '{1, 3, 4, 1, 1,10, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1}; // add x10 again
    tbl[20] = '{1,10,10, 1, 1,11, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1}; // add x11,x10,x10
    tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0, 1, 1}; // M beats W
    tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 2, 1, 1}; // bare redirect
    tbl[23] = '{1, 1, 0, 1, 0,12, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1, 2}; // lw x12
    tbl[24] = '{1,12,12, 0, 0,13, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2}; // sources unused
    tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2};
    tbl[26] = '{1, 1, 0, 1, 0,12, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1, 2}; // lw x12
    tbl[27] = '{0,12,12, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2}; // d_valid=0
    tbl[28] = '{1, 1, 0, 1, 0,13, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1, 2}; // lw x13
    tbl[29] = '{1,13, 2, 1, 1,14, 1, 0, 0,   1, 0, 1, 0, 0, 1, 1, 2}; // rs1 load-use
    tbl[30] = '{1,13, 2, 1, 1,14, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2, 2};
    tbl[31] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 0, 2, 2}; // A from W
    lw5  = '{1, 1, 0, 1, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    cons = '{1, 2, 5, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};

    rest = 1'b1;
    a_v = 0; a_rs1 = 0; a_rs2 = 0; a_u1 = 0; a_u2 = 0; a_rd = 0; a_we = 0; a_ld = 0; a_rdr = 0;
    n_v = 0; n_rs1 = 0; n_rs2 = 0; n_u1 = 0; n_u2 = 0; n_rd = 0; n_we = 0; n_ld = 0; n_rdr = 0;

    // Reset state
    #2;
    chk("rst stall_fd", a_stall, 0);
    chk("rst hz_state", a_hz, 0);
    chk("rst fwd_a", a_fa, 0);
    chk("rst fwd_b", a_fb, 0);
    chk("rst stall_cnt", a_sc, 0);
    chk("rst flush_cnt", a_fc, 0);
    chk("rst b stall_cnt", b_sc, 0);
    chk("rst c stall_cnt", c_sc, 0);
    a_rdr = 1'b1;
    #1;
    chk("rst redirect flush_d", a_flush, 1);
    chk("rst redirect bubble_x", a_bub, 1);
    chk("rst redirect hz_state", a_hz, 0);
    a_rdr = 1'b0;
    @(negedge clk);
    rest = 1'b0;

    for (int i = 0; i < 32; i++) apply_a(i);

    // 20 load-use stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive_a(lw5);
      chk("sat lw no stall", a_stall, 0);
      drive_a(cons);
      chk("sat load-use stall", a_stall, 1);
      drive_a(cons);
      chk("sat released", a_stall, 0);
    end
    chk("sat stall_cnt", a_sc, 15);
    chk("sat flush_cnt", a_fc, 2);

    // Asynchronous reset in the middle of a stall
    drive_a(lw5);
    drive_a(cons);
    chk("mid stall_fd before", a_stall, 1);
    #1;
    rest = 1'b1;
    #1;
    chk("mid rst stall_fd", a_stall, 0);
    chk("mid rst bubble_x", a_bub, 0);
    chk("mid rst hz_state", a_hz, 0);
    chk("mid rst stall_cnt", a_sc, 0);
    chk("mid rst flush_cnt", a_fc, 0);
    a_rdr = 1'b1;
    #1;
    chk("mid rst redirect flush_d", a_flush, 1);
    chk("mid rst redirect bubble_x", a_bub, 1);
    chk("mid rst redirect stall_fd", a_stall, 0);
    @(negedge clk);
    rest = 1'b0;
    a_rdr = 1'b0;
    x_ld = 1'b0;
    m_ld = 1'b0;
    drive_a(cons);
    chk("post rst stall_fd", a_stall, 0);
    chk("post rst stall_cnt", a_sc, 0);
    chk("post rst flush_cnt", a_fc, 0);

    // No-forwarding: add x5 then add x6,x5 held in D while stalled
    drive_n(1, 1, 2, 5);
    chk("nf producer b stall", b_stall, 0);
    chk("nf producer c stall", c_stall, 0);
    for (int i = 0; i < 4; i++) begin
      drive_n(1, 5, 3, 6);
      chk($sformatf("nf c%0d b stall_fd", i), b_stall, eb[i]);
      chk($sformatf("nf c%0d c stall_fd", i), c_stall, ec[i]);
      chk($sformatf("nf c%0d b hz_state", i), b_hz, eb[i]);
      chk($sformatf("nf c%0d c hz_state", i), c_hz, ec[i]);
      chk($sformatf("nf c%0d b fwd_a", i), b_fa, 0);
      chk($sformatf("nf c%0d b fwd_b", i), b_fb, 0);
      chk($sformatf("nf c%0d c fwd_a", i), c_fa, 0);
      chk($sformatf("nf c%0d c fwd_b", i), c_fb, 0);
    end
    drive_n(0, 0, 0, 0);
    chk("nf b stall_cnt", b_sc, 2);
    chk("nf c stall_cnt", c_sc, 3);
    chk("nf b fwd_a", b_fa, 0);
    chk("nf c fwd_a", c_fa, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard controller for the 5-stage (F/D/X/M/W) RISC-V pipeline; it succeeds the purely combinational forwarding-select unit.
- Keeps a shadow scoreboard of the instructions in X, M and W. From it the block generates operand forwarding selects, load-use stalls and branch/jump flushes.
- Supports a no-forwarding mode and saturating stall/flush performance counters.
- Sits beside the datapath: inputs come from D-stage decode and the X-stage branch resolution; outputs drive the PC/D hold, the D/X bubble injection and the X operand muxes.

Parameters:
AW, 5, register address width (x0 at address 0 is never a hazard source).
MODE_FWD, 1, 1 = forward from M/W and stall only on load-use; 0 = no forwarding, stall on any RAW against in-flight writers.
RF_WRITE_FIRST, 1, 1 = register file returns same-cycle write data on read; 0 = a W-stage writer is a hazard to D.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
rest  in  1  asynchronous active-high reset.
d_valid  in  1  D stage holds a real instruction.
d_rs1  in  AW  D source register 1.
d_rs2  in  AW  D source register 2.
d_use_rs1  in  1  D instruction reads rs1.
d_use_rs2  in  1  D instruction reads rs2.
d_rd  in  AW  D destination register.
d_we  in  1  D instruction writes rd.
d_load  in  1  D instruction is a load.
x_redirect  in  1  branch taken or jump resolved in X this cycle.
stall_fd  out  1  hold PC and D register.
flush_d  out  1  D register loads NOP next edge.
bubble_x  out  1  X register loads NOP next edge.
fwd_a_sel  out  2  X operand A source: 0 = RS1X, 1 = ALUM, 2 = DATA_W.
fwd_b_sel  out  2  X operand B source, same encoding.
hz_state  out  2  0 = RUN, 1 = STALL, 2 = FLUSH (combinational debug).
stall_cnt  out  CNT_W  cycles with stall_fd=1, saturating.
flush_cnt  out  CNT_W  cycles with x_redirect=1, saturating.

Behaviour:
- Scoreboard entries X, M, W each hold: valid, rd, we, load, rs1, rs2, use_rs1, use_rs2. An entry is a "writer" when valid & we & rd!=0.
- Scoreboard update on each rising edge:
  - X <= bubble_x ? invalid : D inputs (valid = d_valid).
  - M <= X; W <= M.
  - M and W always advance; the scoreboard never stalls beyond X.
- Match(E, r): E is a writer and E.rd == r. A D source counts only when d_valid & use & rs != 0.
- Hazard, MODE_FWD=1: X is a load and matches any used D source.
- Hazard, MODE_FWD=0: any used D source matches X or M; or matches W when RF_WRITE_FIRST=0.
- Stall and flush outputs (combinational, same cycle):
  - stall_fd = hazard & !x_redirect.
  - flush_d = x_redirect.
  - bubble_x = stall_fd | x_redirect.
- Redirect beats stall: the stalled D instruction is wrong-path and is killed. The redirecting X instruction still advances to M.
- Forwarding, MODE_FWD=1, for X.rs1 when X.valid & X.use_rs1:
  - fwd_a_sel = 1 if Match(M, X.rs1).
  - else fwd_a_sel = 2 if Match(W, X.rs1).
  - else fwd_a_sel = 0.
  - M has priority over W. fwd_b_sel is identical using rs2.
  - A load in M is never a forward source; the load-use stall guarantees the case cannot occur, and the bench asserts this.
- MODE_FWD=0: fwd_a_sel = fwd_b_sel = 0 always.
- hz_state: FLUSH if x_redirect; else STALL if stall_fd; else RUN.
- Counters: +1 per cycle the condition holds; hold at all-ones (no wrap).
- Latency: hazard-to-stall and redirect-to-flush are 0 cycles (combinational). A load-use stall with MODE_FWD=1 lasts exactly 1 cycle.
- Reset (async, any time, including mid-stall):
  - All scoreboard entries become invalid; counters = 0.
  - hz_state, stall_fd, fwd sels = 0 while rest=1.
  - flush_d and bubble_x follow x_redirect.

Test Plan:
1. MODE_FWD=1: add x5,x1,x2 then add x6,x5,x3 back-to-back -> consumer in X has fwd_a_sel=1, no stall; with one instruction between them -> fwd_a_sel=2.
2. lw x5,0(x1) then add x6,x2,x5 -> stall_fd=1 and bubble_x=1 for exactly one cycle; next cycle consumer in X has fwd_b_sel=2; stall_cnt=1.
3. Writers to x0 (lw x0 / add x0) followed by readers of x0 -> no stall, fwd sels stay 0.
4. Load-use hazard with x_redirect=1 in the same cycle -> stall_fd=0, flush_d=1, bubble_x=1, hz_state=2; flush_cnt=1, stall_cnt unchanged.
5. MODE_FWD=0: add x5 then add x6,x5 -> stall 2 cycles with RF_WRITE_FIRST=1, 3 cycles with RF_WRITE_FIRST=0; fwd sels always 0.
6. CNT_W=4: 20 consecutive load-use stalls -> stall_cnt saturates at 15. Assert rest mid-stall -> stall_fd=0 and counters=0 immediately, with no clock edge needed.
